// File: rtl/i2c_slave.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// write bytes delivered on rx_data/rx_valid, read bytes served from tx_data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } state_t;

  state_t     state;
  logic       scl_m, scl_s, scl_q;
  logic       sda_m, sda_s, sda_q;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       rw;
  logic       pend;
  logic       sda_oe;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Reset gates the pull-down directly so the bus is freed without a clock edge.
  assign i2c_sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_q & sda_s;

  // Two-stage synchronizers plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_q <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_m <= i2c_scl;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= i2c_sda;
      sda_s <= sda_m;
      sda_q <= sda_s;
    end
  end

  // pend marks "byte/ACK phase complete, act on the next SCL fall".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      rw       <= 1'b0;
      pend     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_done  <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd7;
        sda_oe  <= 1'b0;
        pend    <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        pend   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise && !pend) begin
              shift <= {shift[6:0], sda_s};
              if (bit_cnt == 3'd0) begin
                if (shift[6:0] == SLAVE_ADDR) begin
                  rw   <= sda_s;
                  busy <= 1'b1;
                  pend <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && pend) begin
              pend   <= 1'b0;
              sda_oe <= 1'b1;
              state  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rw) begin
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end
          WRITE: begin
            if (scl_rise && !pend) begin
              shift <= {shift[6:0], sda_s};
              if (bit_cnt == 3'd0) begin
                rx_data  <= {shift[6:0], sda_s};
                rx_valid <= 1'b1;
                pend     <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && pend) begin
              pend   <= 1'b0;
              sda_oe <= 1'b1;
              state  <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= WRITE;
            end
          end
          READ: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= READ_ACK;
              end else begin
                sda_oe  <= ~shift[3'(bit_cnt - 3'd1)];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise && !pend) begin
              tx_done <= 1'b1;
              if (!sda_s) begin
                pend <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && pend) begin
              pend    <= 1'b0;
              shift   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 3'd7;
              state   <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master at clk/32, vector table, random transfers
// checked against a transaction-level model, and hand sequences for corner cases.
module tb_i2c_slave;

  localparam int unsigned Q   = 8;
  localparam logic [6:0]  SLV = 7'h50;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       busy;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(SLV)) dut (
    .clk     (clk),
    .rst     (rst),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_done (tx_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int tx_cnt      = 0;
  int dut_low     = 0;
  logic [7:0] rxq[$];

  // Passive monitor: written bytes, read-ack pulses, and cycles where the target pulls SDA low.
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_done) tx_cnt++;
    if (!m_low && sda === 1'b0) dut_low++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [1:0]  n;
    logic [23:0] data;
    logic        exp_ack;
    logic [1:0]  exp_cnt;
    logic [23:0] exp_bytes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [23:0] d, input int i);
    logic [23:0] t;
    t = d << (8 * i);
    return t[23:16];
  endfunction

  // Transaction-level model: only the matching address answers; reads of a silent bus float high.
  function automatic void ref_model(input logic [6:0] addr, input logic rw, input int n,
                                    input logic [23:0] data, output logic ea, output int ec,
                                    output logic [23:0] eb);
    ea = (addr == SLV);
    ec = ea ? n : 0;
    eb = (rw && !ea) ? 24'hFFFFFF : data;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_low = !b;
    wait_q();
    scl = 1'b1;
    wait_q();
    s = (sda !== 1'b0);
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, s);
    acked = !s;
  endtask

  // tx_data is scrambled mid-byte to confirm it only matters at load points.
  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
      if (i == 7) tx_data = 8'($urandom);
    end
    tx_data = next_tx;
    bit_cycle(!mack, s);
  endtask

  task automatic run_txn(input string tag, input logic [6:0] addr, input logic rw, input int n,
                         input logic [23:0] data, input logic exp_ack, input int exp_cnt,
                         input logic [23:0] exp_bytes);
    int rx_base, tx_base, low_base;
    logic ack;
    logic [7:0] d;
    rx_base  = rxq.size();
    tx_base  = tx_cnt;
    low_base = dut_low;
    tx_data  = byte_of(data, 0);
    i2c_start();
    send_byte({addr, rw}, ack);
    check({tag, " addr_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, " busy_after_addr"}, 32'(busy), 32'(exp_ack));
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        send_byte(byte_of(data, i), ack);
        check({tag, " wr_ack"}, 32'(ack), 32'(exp_ack));
      end else begin
        read_byte(i != n - 1, (i + 1 < n) ? byte_of(data, i + 1) : 8'h00, d);
        check({tag, " rd_byte"}, 32'(d), 32'(byte_of(exp_bytes, i)));
      end
    end
    if (rw) check({tag, " busy_after_nack"}, 32'(busy), 32'd0);
    i2c_stop();
    wait_q();
    check({tag, " busy_after_stop"}, 32'(busy), 32'd0);
    if (rw) check({tag, " tx_done_cnt"}, 32'(tx_cnt - tx_base), 32'(exp_cnt));
    else    check({tag, " rx_valid_cnt"}, 32'(rxq.size() - rx_base), 32'(exp_cnt));
    if (!rw)
      for (int i = 0; i < n && rx_base + i < rxq.size(); i++)
        check({tag, " rx_byte"}, 32'(rxq[rx_base + i]), 32'(byte_of(exp_bytes, i)));
    if (!exp_ack) check({tag, " silent"}, 32'(dut_low - low_base), 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    logic ack, s, ea;
    logic [7:0] d;
    logic [6:0] ra;
    logic rrw;
    logic [23:0] rdat, eb;
    int rn, ec, rx_base, tx_base;

    tbl[0] = '{7'h50, 1'b0, 2'd1, 24'hA50000, 1'b1, 2'd1, 24'hA50000};
    tbl[1] = '{7'h51, 1'b0, 2'd1, 24'hFF0000, 1'b0, 2'd0, 24'hFF0000};
    tbl[2] = '{7'h50, 1'b1, 2'd1, 24'h3C0000, 1'b1, 2'd1, 24'h3C0000};
    tbl[3] = '{7'h50, 1'b0, 2'd3, 24'h112233, 1'b1, 2'd3, 24'h112233};
    tbl[4] = '{7'h50, 1'b1, 2'd3, 24'hA55A01, 1'b1, 2'd3, 24'hA55A01};
    tbl[5] = '{7'h2A, 1'b1, 2'd2, 24'h123456, 1'b0, 2'd0, 24'hFFFF00};

    rst = 1'b1;
    scl = 1'b1;
    m_low = 1'b0;
    tx_data = 8'h00;
    repeat (4) @(negedge clk);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sda_released", 32'(sda !== 1'b0), 32'd1);
    rst = 1'b0;
    wait_q();

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rw, int'(tbl[i].n), tbl[i].data,
              tbl[i].exp_ack, int'(tbl[i].exp_cnt), tbl[i].exp_bytes);

    // Write then repeated START into a two-byte read.
    rx_base = rxq.size();
    tx_base = tx_cnt;
    tx_data = 8'h81;
    i2c_start();
    send_byte(8'hA0, ack);
    check("rs addr_w_ack", 32'(ack), 32'd1);
    send_byte(8'h7E, ack);
    check("rs data_ack", 32'(ack), 32'd1);
    i2c_start();
    send_byte(8'hA1, ack);
    check("rs addr_r_ack", 32'(ack), 32'd1);
    read_byte(1'b1, 8'h42, d);
    check("rs rd0", 32'(d), 32'h81);
    read_byte(1'b0, 8'h00, d);
    check("rs rd1", 32'(d), 32'h42);
    i2c_stop();
    wait_q();
    check("rs rx_cnt", 32'(rxq.size() - rx_base), 32'd1);
    if (rxq.size() > rx_base) check("rs rx_byte", 32'(rxq[rx_base]), 32'h7E);
    check("rs rx_data", 32'(rx_data), 32'h7E);
    check("rs tx_done_cnt", 32'(tx_cnt - tx_base), 32'd2);

    // START after half a data byte discards the partial byte.
    rx_base = rxq.size();
    i2c_start();
    send_byte(8'hA0, ack);
    check("partial addr_ack", 32'(ack), 32'd1);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    i2c_start();
    send_byte(8'hA0, ack);
    check("partial re_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h5A, ack);
    check("partial data_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_q();
    check("partial rx_cnt", 32'(rxq.size() - rx_base), 32'd1);
    if (rxq.size() > rx_base) check("partial rx_byte", 32'(rxq[rx_base]), 32'h5A);

    // Reset while the target pulls SDA low during read bit 3.
    tx_data = 8'h00;
    i2c_start();
    send_byte(8'hA1, ack);
    check("rst addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bit_cycle(1'b1, s);
      check("rst rd_bit", 32'(s), 32'd0);
    end
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    check("rst sda_driven", 32'(sda !== 1'b0), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("rst sda_released", 32'(sda !== 1'b0), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    wait_q();
    rst = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
    i2c_stop();
    run_txn("post_rst", 7'h50, 1'b0, 1, 24'hC30000, 1'b1, 1, 24'hC30000);

    for (int k = 0; k < 15; k++) begin
      ra   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      rrw  = 1'($urandom);
      rn   = int'($urandom_range(1, 3));
      rdat = 24'($urandom);
      ref_model(ra, rrw, rn, rdat, ea, ec, eb);
      run_txn($sformatf("rnd%0d", k), ra, rrw, rn, rdat, ea, ec, eb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
